// File: rtl/vram_writer_if.sv
// CPU write-request channel and VRAM write port of vram_writer_m.
// The writer is the bus master. It sinks CPU requests and drives address/data/cs toward gpu_m.
interface vram_writer_if #(
    parameter int VRAM_ADDR_WIDTH = 12
);
    logic                       in_valid;
    logic                       in_ready;
    logic [VRAM_ADDR_WIDTH-1:0] in_addr;
    logic [7:0]                 in_data;
    logic [VRAM_ADDR_WIDTH-1:0] address;
    logic [7:0]                 data;
    logic                       cs;

    modport master (input in_valid, in_addr, in_data, output in_ready, address, data, cs);
    modport slave  (output in_valid, in_addr, in_data, input in_ready, address, data, cs);
endinterface

// File: rtl/vram_writer_m.sv
// Buffers CPU VRAM byte writes and drains them to gpu_m only while vertical blanking is active.
// Defining VRAM_WRITER_FILL_EN adds a fill engine that writes a constant byte over an address range.
module vram_writer_m #(
    parameter int VRAM_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    vram_writer_if.master              bus,
    input  logic                       vblank,
    output logic                       busy,
    input  logic                       fill_start,
    input  logic [VRAM_ADDR_WIDTH-1:0] fill_base,
    input  logic [VRAM_ADDR_WIDTH-1:0] fill_len,
    input  logic [7:0]                 fill_value,
    output logic                       fill_busy
);
    localparam int AW = VRAM_ADDR_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);

`ifdef VRAM_WRITER_FILL_EN
    typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_e;
`else
    typedef enum logic [0:0] {IDLE, DRAIN} state_e;
`endif

    state_e          state_q, state_d;
    logic            win_q;
    logic [AW+7:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic            cs_q, cs_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            full, empty, push, pop, drain_ok;

    assign full         = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign push         = bus.in_valid && !full;
    assign pop          = drain_ok && win_q && !empty;
    assign bus.in_ready = !full;
    assign bus.cs       = cs_q;
    assign bus.address  = addr_q;
    assign bus.data     = data_q;
    assign busy         = (state_q != IDLE) || !empty || cs_q;

`ifdef VRAM_WRITER_FILL_EN
    logic [AW-1:0] fill_addr_q, fill_addr_d;
    logic [AW-1:0] fill_rem_q, fill_rem_d;
    logic [7:0]    fill_val_q, fill_val_d;

    // The FIFO keeps accepting while a fill runs, but it only drains after the fill finishes.
    assign drain_ok  = (state_q != FILL);
    assign fill_busy = (state_q == FILL);
`else
    logic unused_fill;

    assign drain_ok    = 1'b1;
    assign fill_busy   = 1'b0;
    assign unused_fill = ^{fill_start, fill_base, fill_len, fill_value};
`endif

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (PW+1)'(1);
        else if (!push && pop)
            count_d = count_q - (PW+1)'(1);
    end

    always_comb begin
        state_d = state_q;
        cs_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef VRAM_WRITER_FILL_EN
        fill_addr_d = fill_addr_q;
        fill_rem_d  = fill_rem_q;
        fill_val_d  = fill_val_q;
`endif
        case (state_q)
            IDLE, DRAIN: begin
                // IDLE may pop directly. This gives the one-edge push-to-write latency.
                if (pop) begin
                    cs_d             = 1'b1;
                    {addr_d, data_d} = mem_q[rd_ptr_q];
                end
                state_d = (count_d == '0) ? IDLE : DRAIN;
`ifdef VRAM_WRITER_FILL_EN
                if (state_q == IDLE && empty && fill_start && fill_len != '0) begin
                    state_d     = FILL;
                    fill_addr_d = fill_base;
                    fill_rem_d  = fill_len;
                    fill_val_d  = fill_value;
                end
`endif
            end
`ifdef VRAM_WRITER_FILL_EN
            FILL: begin
                if (win_q) begin
                    cs_d        = 1'b1;
                    addr_d      = fill_addr_q;
                    data_d      = fill_val_q;
                    fill_addr_d = fill_addr_q + AW'(1);
                    fill_rem_d  = fill_rem_q - AW'(1);
                    if (fill_rem_q == AW'(1))
                        state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cs_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
`ifdef VRAM_WRITER_FILL_EN
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            fill_val_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= vblank;
            count_q <= count_d;
            cs_q    <= cs_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
`ifdef VRAM_WRITER_FILL_EN
            fill_addr_q <= fill_addr_d;
            fill_rem_q  <= fill_rem_d;
            fill_val_q  <= fill_val_d;
`endif
        end
    end

    // Storage needs no reset. Entries become visible only through count/pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {bus.in_addr, bus.in_data};
    end
endmodule
